// File: rtl/imm_synth.sv
// imm_synth: turns a 32-bit constant plus destination register into the shortest
// MIPS load sequence (ori | addiu | lui | lui+ori), one word per cycle on a valid/ready stream.
module imm_synth #(
  parameter int unsigned USE_ADDIU = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic [4:0]       in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ins,
  output logic             out_last,
  output logic [CNT_W-1:0] emit_cnt
);

  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_second;

  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic [31:0] w_first;
  logic [31:0] w_second;
  logic        w_single;

  assign w_hi = in_value[31:16];
  assign w_lo = in_value[15:0];

  // Classification of the incoming constant; only consumed on the accept cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_first  = {OP_ORI, 5'd0, in_rt, w_lo};
    w_second = {OP_ORI, in_rt, in_rt, w_lo};
    w_single = 1'b1;
    if (w_hi == 16'h0000) begin
      w_first = {OP_ORI, 5'd0, in_rt, w_lo};
    end else if ((USE_ADDIU != 0) && (w_hi == 16'hFFFF) && w_lo[15]) begin
      w_first = {OP_ADDIU, 5'd0, in_rt, w_lo};
    end else if (w_lo == 16'h0000) begin
      w_first = {OP_LUI, 5'd0, in_rt, w_hi};
    end else begin
      w_first  = {OP_LUI, 5'd0, in_rt, w_hi};
      w_single = 1'b0;
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // update in this block sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_second  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ins   <= '0;
      emit_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            out_ins   <= w_first;
            out_last  <= w_single;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            r_second  <= w_second;
            r_state   <= EMIT1;
          end
        end
        EMIT1: begin
          if (out_ready) begin
            emit_cnt <= emit_cnt + CNT_W'(1);
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              r_state   <= IDLE;
            end else begin
              out_ins  <= r_second;
              out_last <= 1'b1;
              r_state  <= EMIT2;
            end
          end
        end
        EMIT2: begin
          if (out_ready) begin
            emit_cnt  <= emit_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imm_synth.md
Name: imm_synth

Overview:
- Inverse of the immediate extender: takes a 32-bit constant and a destination register number, and emits the shortest MIPS instruction sequence that loads that constant into the register.
- Sequence is one of ori / addiu / lui alone, or lui followed by ori.
- Sits between the boot/test-program loader and instruction memory.
- Instructions leave one per cycle over a valid/ready stream.

Parameters:
- USE_ADDIU, 1, when 1 a sign-extendable negative constant is emitted as a single addiu; when 0 it falls through to lui+ori.
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request carries a constant.
- in_ready  output  1  block can accept a request this cycle.
- in_value  input  32  constant to load.
- in_rt  input  5  destination register number.
- out_valid  output  1  out_ins holds a valid instruction.
- out_ready  input  1  consumer takes out_ins this cycle.
- out_ins  output  32  encoded MIPS instruction word.
- out_last  output  1  out_ins is the final word of the current sequence.
- emit_cnt  output  CNT_W  total words handed off since reset; wraps modulo 2^CNT_W.

Behaviour:
- Only clk is used. reset is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_last=0, out_ins=0, emit_cnt=0.
- Reset mid-sequence discards the pending sequence; nothing further is emitted for it.
- Handshakes:
  - Accept happens when in_valid & in_ready.
  - Handoff happens when out_valid & out_ready.
  - in_ready = (state==IDLE). It is registered-state-derived, not combinational from out_ready.
- On accept, latch V=in_value and R=in_rt, classify, and go to EMIT1.
- out_valid rises the cycle after accept, giving latency 1.
- Classification, first match wins (H=V[31:16], L=V[15:0]):
  1. H==0 → ORI1: {6'b001101, 5'd0, R, L}. Single word. Zero-extend case; V==0 takes this path.
  2. USE_ADDIU && H==16'hFFFF && L[15]==1 → ADDIU1: {6'b001001, 5'd0, R, L}. Single word. Sign-extend case.
  3. L==0 → LUI1: {6'b001111, 5'd0, R, H}. Single word.
  4. Otherwise → LUI+ORI: first {6'b001111, 5'd0, R, H}, then {6'b001101, R, R, L}.
- State machine:
  - IDLE → EMIT1 on accept.
  - EMIT1: out_valid=1, out_ins=first word, out_last=1 for single-word cases, else 0.
    - On handoff: single-word → IDLE; two-word → EMIT2.
  - EMIT2: out_valid=1, out_ins=ori word, out_last=1. On handoff → IDLE.
- Stall rule: while out_valid & !out_ready, out_ins and out_last hold stable and the state does not advance.
- Throughput:
  - A new request is accepted in the IDLE cycle after the last handoff, so there is one bubble cycle between sequences.
  - Max rate is 1 word/cycle inside a sequence.
- emit_cnt increments by 1 on every handoff and wraps from 2^CNT_W−1 to 0.
- in_rt==0 is encoded normally with no special case, since writes to $0 are harmless.
- in_value and in_rt are sampled only at accept. Later input changes do not affect the sequence in flight.

Test Plan:
- After reset, in_value=0x00001234, in_rt=8, out_ready=1 → one word 0x34081234, out_last=1; in_ready back to 1 one cycle later; emit_cnt=1.
- in_value=0xFFFF8000, in_rt=9, USE_ADDIU=1 → single word 0x24098000, out_last=1. Rebuild with USE_ADDIU=0 → 0x3C09FFFF (out_last=0), then 0x35298000 (out_last=1).
- in_value=0x12340000, in_rt=10 → single word 0x3C0A1234. in_value=0 → 0x34080000 for rt=8.
- in_value=0x12345678, in_rt=11, out_ready held 0 for 3 cycles:
  - out_ins stays 0x3C0B1234 and in_ready stays 0 throughout.
  - Raise out_ready → 0x356B5678 with out_last=1.
  - emit_cnt advances by exactly 2.
- Assert reset while in EMIT2 of the 0x12345678 sequence → next cycle out_valid=0, in_ready=1, emit_cnt=0. The ori word never appears.
- CNT_W=2: issue three lui+ori requests (6 words) → emit_cnt sequence 1,2,3,0,1,2.
